// File: rtl/branch_pc_control.sv
// rtl/branch_pc_control.sv - program counter owner with not-taken prediction and BEQ/BNE redirect/flush
module branch_pc_control #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_type,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_offset,
    input  logic        equal,
    output logic [31:0] pc,
    output logic        flush,
    output logic        taken,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 so flush stays high FLUSH_CYCLES cycles in total.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        taken_q, taken_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        type_q, type_d;
    logic [31:0] target_q, target_d;

    logic [31:0] pc_seq;
    logic [31:0] br_target;
    logic        take;

    // Sequential fetch address, branch target arithmetic and taken decision.
    always_comb begin
        pc_seq    = stall ? pc_q : (pc_q + 32'd4);
        br_target = (br_pc & 32'hFFFF_FFFC) + 32'd4
                    + {{14{br_offset[15]}}, br_offset, 2'b00};
        take      = type_q ? ~equal : equal;
    end

    // Next-state and next-output logic for the RUN / RESOLVE / REDIRECT machine.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_seq;
        flush_d  = flush_q;
        taken_d  = 1'b0;
        cnt_d    = cnt_q;
        type_d   = type_q;
        target_d = target_q;

        case (state_q)
            ST_RUN: begin
                if (br_valid) begin
                    type_d   = br_type;
                    target_d = br_target;
                    state_d  = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                if (take) begin
                    pc_d    = target_q;
                    taken_d = 1'b1;
                    flush_d = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                flush_d = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            taken_q  <= 1'b0;
            cnt_q    <= 4'd0;
            type_q   <= 1'b0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
            target_q <= target_d;
        end
    end

    assign pc    = pc_q;
    assign flush = flush_q;
    assign taken = taken_q;
    assign busy  = (state_q != ST_RUN);

endmodule

// File: tb/tb_branch_pc_control.sv
// tb/tb_branch_pc_control.sv - randomized self-checking bench for branch_pc_control
module tb_branch_pc_control;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_type = 1'b0;
    logic [31:0] br_pc = 32'd0;
    logic [15:0] br_offset = 16'd0;
    logic        equal = 1'b0;
    logic [31:0] pc;
    logic        flush;
    logic        taken;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pending branch awaiting resolution, and flush cycles still owed.
    logic [31:0] m_pc = 32'd0;
    logic        m_taken = 1'b0;
    logic        m_pending = 1'b0;
    logic        m_ptype = 1'b0;
    logic [31:0] m_ptarget = 32'd0;
    int          m_flush_left = 0;
    logic        prev_taken = 1'b0;

    branch_pc_control #(
        .RESET_PC    (RESET_PC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_valid (br_valid),
        .br_type  (br_type),
        .br_pc    (br_pc),
        .br_offset(br_offset),
        .equal    (equal),
        .pc       (pc),
        .flush    (flush),
        .taken    (taken),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] branch_target(input logic [31:0] bpc, input logic [15:0] boff);
        logic [31:0] off_words;
        off_words = 32'($signed(boff));
        return (bpc & 32'hFFFF_FFFC) + 32'd4 + off_words * 32'd4;
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] cur, input logic st);
        return st ? cur : cur + 32'd4;
    endfunction

    // Advance the model by one clock using the inputs the DUT sees at this edge.
    task automatic model_step();
        if (reset) begin
            m_pc         = RESET_PC;
            m_taken      = 1'b0;
            m_pending    = 1'b0;
            m_flush_left = 0;
        end else if (m_pending) begin
            m_pending = 1'b0;
            if (m_ptype ? !equal : equal) begin
                m_pc         = m_ptarget;
                m_taken      = 1'b1;
                m_flush_left = FLUSH_CYCLES;
            end else begin
                m_pc    = next_seq(m_pc, stall);
                m_taken = 1'b0;
            end
        end else if (m_flush_left > 0) begin
            m_pc         = next_seq(m_pc, stall);
            m_taken      = 1'b0;
            m_flush_left = m_flush_left - 1;
        end else begin
            if (br_valid) begin
                m_pending = 1'b1;
                m_ptype   = br_type;
                m_ptarget = branch_target(br_pc, br_offset);
            end
            m_pc    = next_seq(m_pc, stall);
            m_taken = 1'b0;
        end
    endtask

    // Apply one cycle of inputs, clock, update the model and compare all outputs.
    task automatic cycle(input logic rst, input logic st, input logic bv, input logic bt,
                         input logic [31:0] bpc, input logic [15:0] boff, input logic eq);
        reset     = rst;
        stall     = st;
        br_valid  = bv;
        br_type   = bt;
        br_pc     = bpc;
        br_offset = boff;
        equal     = eq;
        @(posedge clk);
        model_step();
        #1;
        check("pc", pc, m_pc);
        check("flush", 32'(flush), 32'(m_flush_left > 0));
        check("taken", 32'(taken), 32'(m_taken));
        check("busy", 32'(busy), 32'(m_pending || (m_flush_left > 0)));
        if (!rst) check("taken_not_consecutive", 32'(prev_taken && taken), 32'd0);
        prev_taken = taken;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset, then free-running fetch.
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("reset_pc", pc, RESET_PC);
        check("reset_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        check("run_pc16", pc, 32'h10);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        check("run_pc20", pc, 32'h20);

        // Taken BEQ: target 0x1C + 4 + 12 = 0x2C.
        cycle(0, 0, 1, 0, 32'h1C, 16'd3, 0);
        check("beq_busy", 32'(busy), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("beq_pc", pc, 32'h2C);
        check("beq_taken", 32'(taken), 32'd1);
        check("beq_flush", 32'(flush), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("beq_pc30", pc, 32'h30);
        check("beq_flush2", 32'(flush), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("beq_pc34", pc, 32'h34);
        check("beq_flush_off", 32'(flush), 32'd0);

        // Not-taken BEQ: pc keeps counting, busy one cycle.
        cycle(0, 0, 1, 0, 32'h30, 16'd3, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("nt_pc", pc, 32'h3C);
        check("nt_taken", 32'(taken), 32'd0);
        check("nt_busy", 32'(busy), 32'd0);

        // BNE with negative offset, then wrap.
        cycle(0, 0, 1, 1, 32'h100, 16'hFFFC, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("bne_pc", pc, 32'hF4);
        for (int i = 0; i < FLUSH_CYCLES; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 32'h0, 16'hFFFC, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check("bne_wrap", pc, 32'hFFFF_FFF4);
        for (int i = 0; i < FLUSH_CYCLES + 2; i++) cycle(0, 0, 0, 0, 0, 0, 0);
        check("wrap_zero", pc, 32'h4);

        // Stall held through resolve and redirect; br_valid during redirect ignored.
        cycle(0, 1, 1, 0, 32'h200, 16'd8, 0);
        check("stall_hold", pc, 32'h4);
        cycle(0, 1, 0, 0, 0, 0, 1);
        check("stall_target", pc, 32'h224);
        cycle(0, 1, 1, 0, 32'h400, 16'd1, 1);
        check("stall_hold2", pc, 32'h224);
        cycle(0, 1, 0, 0, 0, 0, 1);
        check("stall_flush_off", 32'(flush), 32'd0);
        cycle(0, 1, 0, 0, 0, 0, 1);
        check("ignored_br", pc, 32'h224);
        check("ignored_busy", 32'(busy), 32'd0);

        // Reset during resolve beats a taken branch.
        cycle(0, 0, 1, 0, 32'h80, 16'd5, 0);
        cycle(1, 0, 0, 0, 0, 0, 1);
        check("rst_res_pc", pc, RESET_PC);
        check("rst_res_taken", 32'(taken), 32'd0);
        check("rst_res_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) == 0),
                  1'($urandom),
                  $urandom,
                  16'($urandom),
                  1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pc_control.md
Name: branch_pc_control

Overview:
Downstream consumer of the registered `equal` flag produced by the operand-compare stage. It owns the program counter. It speculatively fetches sequentially (predict not-taken) and resolves BEQ/BNE one cycle after issue, when `equal` is valid. On a taken branch it redirects the PC and raises `flush` for a fixed number of cycles so the fetch/decode stages discard wrong-path instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.
FLUSH_CYCLES, 2, number of cycles `flush` stays high after a taken redirect; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  freeze sequential PC advance (hazard from downstream)
br_valid  input  1  branch instruction issued this cycle; accepted only when busy=0
br_type  input  1  0 = BEQ (taken if equal), 1 = BNE (taken if !equal)
br_pc  input  32  PC of the issuing branch; bits [1:0] ignored (treated as 0)
br_offset  input  16  signed word offset from the instruction immediate
equal  input  1  registered compare result; valid in the cycle after br_valid
pc  output  32  current fetch PC, registered
flush  output  1  registered; high while wrong-path instructions must be squashed
taken  output  1  registered one-cycle pulse marking a taken branch resolution
busy  output  1  high when state != RUN; upstream holds further branches

Behaviour:
- Reset (reset=1 at a rising edge, any state): pc=RESET_PC, flush=0, taken=0, state=RUN, flush counter=0. Reset has priority over every other input, including mid-RESOLVE and mid-REDIRECT.
- States: RUN, RESOLVE, REDIRECT. `busy` is decoded from state.
- PC advance: `pc <= pc + 4` (mod 2^32, wraps 32'hFFFF_FFFC -> 0) every cycle stall=0, except when a redirect overrides it.
- RUN:
  - If br_valid=1, latch br_type, target, and move to RESOLVE. This happens regardless of stall.
  - target = {br_pc[31:2],2'b00} + 4 + (sign_extend(br_offset) << 2), computed mod 2^32.
  - PC keeps advancing per the stall rule.
- RESOLVE (T+1 when br_valid was at T):
  - br_valid is ignored. Sample `equal`; take = br_type ? ~equal : equal.
  - take=1: pc <= target (overrides stall), taken <= 1, flush <= 1, counter <= FLUSH_CYCLES-1, go REDIRECT.
  - take=0: PC advances per the stall rule, taken <= 0, go RUN.
  - Resolution occurs even if stall=1.
- REDIRECT:
  - flush stays 1. PC advances from target per the stall rule. taken <= 0 after its single-cycle pulse.
  - If counter=0: flush <= 0 and go RUN. Otherwise decrement the counter. The counter decrements regardless of stall.
  - br_valid is ignored.
- Latency: br_valid at cycle T. At T+2, pc=target, taken=1, flush=1. flush is high for exactly FLUSH_CYCLES cycles (T+2 .. T+1+FLUSH_CYCLES). busy is high T+1 .. T+1+FLUSH_CYCLES on taken; T+1 only on not-taken.
- taken is never high in two consecutive cycles.
- No back-to-back branch acceptance: a br_valid while busy=1 has no effect and is not queued.

Test Plan:
- Reset then run, stall=0 for 4 cycles -> pc = 0,4,8,12,16; flush=0, taken=0, busy=0.
- br_valid at pc=0x20, br_pc=0x1C, BEQ, offset=+3, equal=1 next cycle -> two cycles later pc=0x2C, taken pulse 1 cycle, flush high 2 cycles, then pc=0x30,0x34.
- Same stimulus but equal=0 -> no redirect, pc continues +4, taken=0, flush=0, busy high 1 cycle.
- BNE, br_pc=0x100, offset=16'hFFFC (-4), equal=0 -> pc=0xF4. With br_pc=0x0 and same offset -> pc=0xFFFF_FFF4 (wrap).
- stall=1 held through RESOLVE and REDIRECT on a taken BEQ -> pc jumps to target and then holds; flush still drops after FLUSH_CYCLES; a br_valid pulsed during REDIRECT is ignored.
- reset asserted in the RESOLVE cycle with equal=1 -> next cycle pc=RESET_PC, flush=0, taken=0, busy=0, no redirect.
